fireball_draw: RTL and testbench
================================

FIREBALL_DRAW -- requirements
Module: fireball_draw

Interface
REQ-001 Parameter LIFE_FRAMES, default 30, number of frame_clk rising edges the fireball stays visible after a trigger (range 9..255).
REQ-002 Parameter TRANSP_IDX, default 391, palette index treated as transparent.
REQ-003 Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 frame_clk  input  1  vertical-sync-derived frame strobe, synchronous to Clk; only its rising edge is used.
REQ-006 trigger  input  1  single-cycle request to spawn a fireball.
REQ-007 fire_x, fire_y  input  10 each  top-left screen position of the 32x32 sprite; sampled on trigger.
REQ-008 DrawX, DrawY  input  10 each  current VGA pixel coordinate.
REQ-009 sprite_row, sprite_col  output  5 each  registered address into the fireball sprite ROM.
REQ-010 sprite_idx  input  10  palette index returned by the sprite ROM for (sprite_row, sprite_col); combinational, same cycle.
REQ-011 draw_en  output  1  registered; 1 when color_idx must overwrite the background pixel.
REQ-012 color_idx  output  10  registered palette index for the pixel.
REQ-013 active  output  1  registered; 1 while the state machine is in SHOW or FADE.

Function
REQ-014 Edge detect: frame_clk is registered once; frame_tick = frame_clk AND NOT frame_clk_q.
REQ-015 States: IDLE, SHOW, FADE; life counter is 8 bits.
REQ-016 IDLE: on trigger, latch fire_x/fire_y, load life counter with LIFE_FRAMES, go to SHOW.
REQ-017 SHOW: each frame_tick decrements the counter; when the counter reaches 8, go to FADE.
REQ-018 FADE: each frame_tick decrements the counter; when the counter reaches 0, go to IDLE.
REQ-019 trigger in SHOW or FADE restarts: re-latch position, reload LIFE_FRAMES, go to SHOW; trigger takes priority over a coincident frame_tick.
REQ-020 Stage 1 (cycle N): in_box = (DrawX - px) and (DrawY - py) both in 0..31, computed in 11-bit unsigned arithmetic so that px+31 > 639 clips without wrap-around; register in_box, sprite_col = DrawX - px [4:0], sprite_row = DrawY - py [4:0].
REQ-021 Stage 2 (cycle N+1): register color_idx = sprite_idx and draw_en = in_box_q AND visible AND (sprite_idx != TRANSP_IDX).
REQ-022 Total latency from DrawX/DrawY to draw_en/color_idx is exactly 2 Clk cycles; throughput is one pixel per cycle.
REQ-023 visible = 1 in SHOW; in FADE as defined in REQ-028/029; 0 in IDLE.
REQ-024 Pixel outside the box or transparent: draw_en = 0; color_idx still carries sprite_idx (don't-care to consumer).
REQ-025 Position and state changes take effect on the pipeline at the next stage-1 register update; no pixel sees a half-updated position.

Reset
REQ-026 Reset asserted asynchronously forces: state IDLE, counter 0, position 0, frame_clk_q 0, in_box_q 0, sprite_row 0, sprite_col 0, draw_en 0, color_idx 0, active 0.
REQ-027 Reset mid-SHOW/FADE discards the fireball; a trigger is required after release to display again.

Configuration
REQ-028 With FIREBALL_FLICKER_EN defined: in FADE, visible = counter[0] (blinks on alternate frames).
REQ-029 Without FIREBALL_FLICKER_EN: in FADE, visible = 1 (solid until expiry); state sequence and timing unchanged.

Verification
REQ-030 Trigger at fire_x=100, fire_y=50, scan DrawX=100..131, DrawY=60 -> draw_en high 2 cycles after each non-transparent pixel, sprite_col 0..31, sprite_row 10.
REQ-031 Pixel at DrawX=100, DrawY=50 (sprite_idx=391) -> draw_en 0; DrawX=99 or 132 -> draw_en 0 regardless of sprite_idx.
REQ-032 fire_x=620, DrawX=639 -> in-box with sprite_col 19; DrawX=0..11 -> never in-box (no wrap).
REQ-033 LIFE_FRAMES=30: active high for exactly 30 frame_ticks; SHOW for 22, FADE for 8; with FIREBALL_FLICKER_EN draw_en toggles per frame in FADE, without it stays solid.
REQ-034 Trigger coincident with frame_tick at counter=3 in FADE -> state SHOW, counter 30, new position used.
REQ-035 Reset pulse in SHOW mid-scanline -> all outputs 0 within the same cycle, state IDLE, no draw_en until next trigger.

Source files
------------

// File: rtl/fireball_draw_if.sv
// Pixel/sprite bus between the fireball renderer and its surroundings.
// Master drives the scan position, trigger, frame strobe and ROM data; slave returns ROM address and pixel.
interface fireball_draw_if;
    logic       frame_clk;
    logic       trigger;
    logic [9:0] fire_x;
    logic [9:0] fire_y;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [4:0] sprite_row;
    logic [4:0] sprite_col;
    logic [9:0] sprite_idx;
    logic       draw_en;
    logic [9:0] color_idx;
    logic       active;

    modport master (
        output frame_clk, trigger, fire_x, fire_y, draw_x, draw_y, sprite_idx,
        input  sprite_row, sprite_col, draw_en, color_idx, active
    );

    modport slave (
        input  frame_clk, trigger, fire_x, fire_y, draw_x, draw_y, sprite_idx,
        output sprite_row, sprite_col, draw_en, color_idx, active
    );
endinterface

// File: rtl/fireball_draw.sv
// Fireball sprite renderer: lifetime FSM (IDLE/SHOW/FADE) plus a 2-stage pixel pipeline.
// Optional macro FIREBALL_FLICKER_EN makes the sprite blink on alternate frames while fading.
module fireball_draw #(
    parameter int unsigned LIFE_FRAMES = 30,
    parameter int unsigned TRANSP_IDX  = 391
) (
    input  logic           clk,
    input  logic           rst,
    fireball_draw_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHOW, FADE} state_t;

    localparam logic [7:0] LIFE_LOAD = 8'(LIFE_FRAMES);
    localparam logic [9:0] TRANSP    = 10'(TRANSP_IDX);

    state_t      state, state_n;
    logic [7:0]  life, life_n;
    logic [9:0]  pos_x, pos_y, pos_x_n, pos_y_n;
    logic        frame_q;
    logic        frame_tick;
    logic        visible;
    logic [10:0] dx, dy;
    logic        in_box;
    logic        in_box_q;
    logic        vis_q;

    assign frame_tick = bus.frame_clk & ~frame_q;

    // A trigger always wins over a frame tick and restarts the full lifetime.
    always_comb begin
        state_n = state;
        life_n  = life;
        pos_x_n = pos_x;
        pos_y_n = pos_y;
        if (bus.trigger) begin
            state_n = SHOW;
            life_n  = LIFE_LOAD;
            pos_x_n = bus.fire_x;
            pos_y_n = bus.fire_y;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                SHOW: begin
                    if (frame_tick) begin
                        life_n = life - 8'd1;
                        if (life == 8'd9) state_n = FADE;
                    end
                end
                FADE: begin
                    if (frame_tick) begin
                        life_n = life - 8'd1;
                        if (life == 8'd1) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        visible = 1'b0;
        case (state)
            SHOW: visible = 1'b1;
`ifdef FIREBALL_FLICKER_EN
            FADE: visible = life[0];
`else
            FADE: visible = 1'b1;
`endif
            default: visible = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            life       <= 8'd0;
            pos_x      <= 10'd0;
            pos_y      <= 10'd0;
            frame_q    <= 1'b0;
            bus.active <= 1'b0;
        end else begin
            state      <= state_n;
            life       <= life_n;
            pos_x      <= pos_x_n;
            pos_y      <= pos_y_n;
            frame_q    <= bus.frame_clk;
            bus.active <= (state_n != IDLE);
        end
    end

    // 11-bit differences so a sprite near the right/bottom edge clips instead of wrapping to 0.
    assign dx     = {1'b0, bus.draw_x} - {1'b0, pos_x};
    assign dy     = {1'b0, bus.draw_y} - {1'b0, pos_y};
    assign in_box = (dx[10:5] == 6'd0) && (dy[10:5] == 6'd0);

    // Visibility travels with the pixel so a state change never splits one pixel's decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_box_q       <= 1'b0;
            vis_q          <= 1'b0;
            bus.sprite_row <= 5'd0;
            bus.sprite_col <= 5'd0;
            bus.color_idx  <= 10'd0;
            bus.draw_en    <= 1'b0;
        end else begin
            in_box_q       <= in_box;
            vis_q          <= visible;
            bus.sprite_row <= dy[4:0];
            bus.sprite_col <= dx[4:0];
            bus.color_idx  <= bus.sprite_idx;
            bus.draw_en    <= in_box_q & vis_q & (bus.sprite_idx != TRANSP);
        end
    end
endmodule

// File: tb/tb_fireball_draw.sv
// Scoreboard bench for fireball_draw: a lifetime/geometry model predicts every pipeline output.
// Build with or without FIREBALL_FLICKER_EN; the model follows the same macro.
module tb_fireball_draw;
    localparam int LIFE   = 30;
    localparam int TRANSP = 391;
`ifdef FIREBALL_FLICKER_EN
    localparam bit FLICKER = 1'b1;
`else
    localparam bit FLICKER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fireball_draw_if bus();

    fireball_draw #(.LIFE_FRAMES(LIFE), .TRANSP_IDX(TRANSP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Sprite ROM stand-in: every fifth diagonal is transparent, the rest a unique colour.
    function automatic logic [9:0] romValue(input logic [4:0] r, input logic [4:0] c);
        int         s;
        logic [9:0] v;
        s = int'(r) + int'(c);
        v = {r, c};
        if (s % 5 == 0) return 10'(TRANSP);
        if (v == 10'(TRANSP)) return 10'd0;
        return v;
    endfunction

    always_comb bus.sprite_idx = romValue(bus.sprite_row, bus.sprite_col);

    typedef struct {
        int         due;
        logic [4:0] row;
        logic [4:0] col;
        logic       act;
    } rc_t;

    typedef struct {
        int         due;
        logic       en;
        logic [9:0] color;
    } px_t;

    rc_t rc_q[$];
    px_t px_q[$];
    int  edge_cnt = 0;
    int  errors   = 0;
    int  checks   = 0;

    // Reference state: frames left to live and the latched top-left corner.
    int  m_life  = 0;
    int  m_px    = 0;
    int  m_py    = 0;
    bit  m_fprev = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Last 8 frames are the fade; with flicker only odd remaining counts are shown.
    function automatic bit modelVisible();
        if (m_life > 8) return 1'b1;
        if (m_life > 0) return (!FLICKER) || (m_life % 2 == 1);
        return 1'b0;
    endfunction

    task automatic applyStimulus(input int x, input int y, input bit trig, input bit fclk,
                                 input int fx, input int fy);
        rc_t        rc;
        px_t        px;
        int         dx, dy;
        bit         inb;
        logic [4:0] r, c;
        bus.draw_x    = 10'(x);
        bus.draw_y    = 10'(y);
        bus.trigger   = trig;
        bus.frame_clk = fclk;
        bus.fire_x    = 10'(fx);
        bus.fire_y    = 10'(fy);
        dx  = x - m_px;
        dy  = y - m_py;
        inb = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
        r   = 5'(dy);
        c   = 5'(dx);
        rc.due   = edge_cnt + 1;
        rc.row   = r;
        rc.col   = c;
        px.due   = edge_cnt + 2;
        px.color = romValue(r, c);
        px.en    = inb && modelVisible() && (px.color != 10'(TRANSP));
        if (trig) begin
            m_life = LIFE;
            m_px   = fx;
            m_py   = fy;
        end else if (fclk && !m_fprev && m_life > 0) begin
            m_life--;
        end
        m_fprev = fclk;
        rc.act  = (m_life > 0);
        rc_q.push_back(rc);
        px_q.push_back(px);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        rc_t rc;
        px_t px;
        if (rc_q.size() > 0 && rc_q[0].due == edge_cnt) begin
            rc = rc_q.pop_front();
            checkOutput("sprite_row", 32'(bus.sprite_row), 32'(rc.row));
            checkOutput("sprite_col", 32'(bus.sprite_col), 32'(rc.col));
            checkOutput("active", 32'(bus.active), 32'(rc.act));
        end
        if (px_q.size() > 0 && px_q[0].due == edge_cnt) begin
            px = px_q.pop_front();
            checkOutput("draw_en", 32'(bus.draw_en), 32'(px.en));
            checkOutput("color_idx", 32'(bus.color_idx), 32'(px.color));
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_draw_en"}, 32'(bus.draw_en), 32'd0);
        checkOutput({tag, "_color_idx"}, 32'(bus.color_idx), 32'd0);
        checkOutput({tag, "_sprite_row"}, 32'(bus.sprite_row), 32'd0);
        checkOutput({tag, "_sprite_col"}, 32'(bus.sprite_col), 32'd0);
        checkOutput({tag, "_active"}, 32'(bus.active), 32'd0);
    endtask

    initial begin
        int x, y;
        bus.draw_x    = '0;
        bus.draw_y    = '0;
        bus.trigger   = 1'b0;
        bus.frame_clk = 1'b0;
        bus.fire_x    = '0;
        bus.fire_y    = '0;

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // Scanline through a sprite at (100,50), including both horizontal neighbours.
        applyStimulus(0, 0, 1'b1, 1'b0, 100, 50);
        for (int i = 99; i <= 132; i++) applyStimulus(i, 60, 1'b0, 1'b0, 0, 0);
        applyStimulus(100, 50, 1'b0, 1'b0, 0, 0);
        applyStimulus(99, 55, 1'b0, 1'b0, 0, 0);
        applyStimulus(132, 55, 1'b0, 1'b0, 0, 0);

        // Full lifetime: one frame edge every 4 cycles, sampling pixels across the sprite.
        for (int i = 0; i < 140; i++)
            applyStimulus(100 + (i % 32), 50 + ((i * 7) % 32), 1'b0, (i % 4 == 0), 0, 0);

        // Right-edge clipping: sprite at x=620 must not wrap into the left columns.
        applyStimulus(0, 0, 1'b1, 1'b0, 620, 100);
        applyStimulus(639, 110, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i <= 11; i++) applyStimulus(i, 110, 1'b0, 1'b0, 0, 0);
        applyStimulus(620, 131, 1'b0, 1'b0, 0, 0);

        // Re-trigger landing on the same cycle as a frame edge while 3 frames remain.
        for (int i = 0; i < 200 && m_life != 3; i++)
            applyStimulus(625 + (i % 15), 100 + (i % 32), 1'b0, (i % 2 == 0), 0, 0);
        if (m_fprev) applyStimulus(630, 105, 1'b0, 1'b0, 0, 0);
        applyStimulus(630, 105, 1'b1, 1'b1, 400, 300);
        for (int i = 0; i < 70; i++)
            applyStimulus(400 + (i % 32), 300 + ((i * 3) % 32), 1'b0, (i % 2 == 1), 0, 0);

        // Randomised traffic around whatever position is currently latched.
        for (int i = 0; i < 400; i++) begin
            x = m_px + int'($urandom_range(0, 40)) - 4;
            y = m_py + int'($urandom_range(0, 40)) - 4;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            applyStimulus(x, y, ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end

        // Asynchronous reset in the middle of a visible scanline.
        applyStimulus(0, 0, 1'b1, 1'b0, 200, 100);
        for (int i = 0; i < 6; i++) applyStimulus(205 + i, 110, 1'b0, 1'b0, 0, 0);
        #2 rst = 1'b1;
        #1 checkAllZero("async_reset");
        rc_q.delete();
        px_q.delete();
        m_life  = 0;
        m_px    = 0;
        m_py    = 0;
        m_fprev = 1'b0;
        bus.trigger   = 1'b0;
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++)
            applyStimulus(200 + (i % 32), 100 + (i % 32), 1'b0, (i % 3 == 0), 0, 0);

        for (int i = 0; i < 10 && (rc_q.size() > 0 || px_q.size() > 0); i++) @(negedge clk);
        if (rc_q.size() > 0 || px_q.size() > 0)
            checkOutput("scoreboard_drain", 32'(rc_q.size() + px_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
